// File: rtl/ram_64_8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_64_8_pkg
//  Purpose  : Shared types and constants for the 64x8 frame-buffer fill stage.
//             Holds the writer FSM state encoding and buffer geometry.
//  Revision : 1.0  initial release
// ============================================================================
package ram_64_8_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 2 ** ADDR_W;
  localparam int MIN_LEN   = 2;

  // A frame is good when all bytes, checksum included, sum to this value.
  localparam logic [7:0] CKSUM_OK = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_64_8_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : ram_64_8_frame_writer
//  Purpose  : Fill stage for the 64x8 frame buffer. Writes an SOF/EOF framed
//             byte stream into the buffer from address 0, verifies the
//             additive checksum and holds a good frame until the reader
//             acknowledges it.
//  Ports    : clk, rst_n            clock, async active-low reset
//             rx_data/vld/sof/eof   incoming byte stream
//             c_addr/c_din/c_wen    buffer write port (registered)
//             frame_rdy/frame_len   good frame resident, payload length
//             frame_ack             reader done, releases buffer
//             err_cksum/len/drop    one-cycle error pulses
//             busy                  FSM not idle
//  Revision : 1.0  initial release
// ============================================================================
module ram_64_8_frame_writer #(
  parameter int ADDR_W  = ram_64_8_pkg::ADDR_W,
  parameter int DATA_W  = ram_64_8_pkg::DATA_W,
  parameter int MIN_LEN = ram_64_8_pkg::MIN_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_vld,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_din,
  output logic              c_wen,
  output logic              frame_rdy,
  output logic [ADDR_W-1:0] frame_len,
  input  logic              frame_ack,
  output logic              err_cksum,
  output logic              err_len,
  output logic              err_drop,
  output logic              busy
);
  import ram_64_8_pkg::*;

  // Byte counter is one bit wider than the address so it can reach the full
  // buffer depth and recognise the first byte that does not fit.
  localparam logic [ADDR_W:0] c_depth   = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] c_min_len = (ADDR_W + 1)'(MIN_LEN);
  localparam logic [ADDR_W:0] c_one     = (ADDR_W + 1)'(1);

  state_t            r_state, state_d;
  logic [ADDR_W:0]   r_cnt, cnt_d;
  logic [DATA_W-1:0] r_sum, sum_d;
  logic [ADDR_W-1:0] r_addr, addr_d;
  logic [DATA_W-1:0] r_din, din_d;
  logic              r_wen, wen_d;
  logic              r_rdy, rdy_d;
  logic [ADDR_W-1:0] r_len, len_d;
  logic              r_err_cksum, err_cksum_d;
  logic              r_err_len, err_len_d;
  logic              r_err_drop, err_drop_d;

  logic              w_accept;
  logic [ADDR_W:0]   w_cnt_base;
  logic [ADDR_W:0]   w_tot;
  logic [DATA_W-1:0] w_sum_acc;

  always_comb begin
    state_d     = r_state;
    cnt_d       = r_cnt;
    sum_d       = r_sum;
    addr_d      = r_addr;
    din_d       = r_din;
    wen_d       = 1'b0;
    rdy_d       = r_rdy;
    len_d       = r_len;
    err_cksum_d = 1'b0;
    err_len_d   = 1'b0;
    err_drop_d  = 1'b0;
    w_accept    = 1'b0;

    // An SOF byte restarts counting and summing from scratch, whether it
    // opens a frame from IDLE or aborts a partial frame in RECV.
    w_cnt_base = rx_sof ? '0 : r_cnt;
    w_tot      = w_cnt_base + c_one;
    w_sum_acc  = (rx_sof ? '0 : r_sum) + rx_data;

    case (r_state)
      IDLE: begin
        w_accept = rx_vld && rx_sof;
      end
      RECV: begin
        w_accept = rx_vld && (rx_sof || (r_cnt != c_depth));
        // Byte that would overflow the buffer: flag once and skip the rest.
        if (rx_vld && !w_accept) begin
          err_len_d = 1'b1;
          state_d   = rx_eof ? IDLE : DISCARD;
        end
      end
      DISCARD: begin
        if (rx_vld && rx_eof) state_d = IDLE;
      end
      HOLD: begin
        // All non-SOF bytes are ignored here, which also covers the tail of
        // a dropped frame including its EOF.
        if (rx_vld && rx_sof) err_drop_d = 1'b1;
        if (frame_ack) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_accept) begin
      wen_d   = 1'b1;
      addr_d  = w_cnt_base[ADDR_W-1:0];
      din_d   = rx_data;
      cnt_d   = w_tot;
      sum_d   = w_sum_acc;
      state_d = RECV;
      if (rx_eof) begin
        if (w_tot < c_min_len) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else if (w_sum_acc != DATA_W'(CKSUM_OK)) begin
          err_cksum_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rdy_d   = 1'b1;
          // Payload length excludes the checksum byte: total - 1.
          len_d   = w_cnt_base[ADDR_W-1:0];
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_wen       <= 1'b0;
      r_rdy       <= 1'b0;
      r_len       <= '0;
      r_err_cksum <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_state     <= state_d;
      r_cnt       <= cnt_d;
      r_sum       <= sum_d;
      r_addr      <= addr_d;
      r_din       <= din_d;
      r_wen       <= wen_d;
      r_rdy       <= rdy_d;
      r_len       <= len_d;
      r_err_cksum <= err_cksum_d;
      r_err_len   <= err_len_d;
      r_err_drop  <= err_drop_d;
    end
  end

  assign c_addr    = r_addr;
  assign c_din     = r_din;
  assign c_wen     = r_wen;
  assign frame_rdy = r_rdy;
  assign frame_len = r_len;
  assign err_cksum = r_err_cksum;
  assign err_len   = r_err_len;
  assign err_drop  = r_err_drop;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_64_8_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_64_8_frame_writer
//  Purpose  : Scoreboard bench for ram_64_8_frame_writer. Stimulus pushes
//             expected buffer writes and expected status events; a monitor
//             pops and compares whenever the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_64_8_frame_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       rx_sof = 1'b0;
  logic       rx_eof = 1'b0;
  logic [5:0] c_addr;
  logic [7:0] c_din;
  logic       c_wen;
  logic       frame_rdy;
  logic [5:0] frame_len;
  logic       frame_ack = 1'b0;
  logic       err_cksum;
  logic       err_len;
  logic       err_drop;
  logic       busy;

  ram_64_8_frame_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .c_addr    (c_addr),
    .c_din     (c_din),
    .c_wen     (c_wen),
    .frame_rdy (frame_rdy),
    .frame_len (frame_len),
    .frame_ack (frame_ack),
    .err_cksum (err_cksum),
    .err_len   (err_len),
    .err_drop  (err_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected writes as {addr, data}; expected events encoded as
  // kind*1000 + wen*100 + len  (kind 1=ready, 2=cksum, 3=len, 4=drop).
  logic [13:0] wq[$];
  int          eq[$];
  logic [7:0]  fb[0:69];
  logic        prev_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic ev_check(input int obs);
    if (eq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%0d required=none", obs);
    end else begin
      chk("event", obs, eq.pop_front());
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial prev_rdy = 1'b0;
  always @(negedge clk) begin
    logic [13:0] e;
    if (c_wen) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=none", c_addr, c_din);
      end else begin
        e = wq.pop_front();
        chk("write", {c_addr, c_din}, e);
      end
    end
    if (frame_rdy && !prev_rdy) ev_check(1000 + 100 * int'(c_wen) + int'(frame_len));
    if (err_cksum) ev_check(2000 + 100 * int'(c_wen));
    if (err_len)   ev_check(3000 + 100 * int'(c_wen));
    if (err_drop)  ev_check(4000 + 100 * int'(c_wen));
    prev_rdy = frame_rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eof);
    rx_data = d;
    rx_vld  = 1'b1;
    rx_sof  = sof;
    rx_eof  = eof;
    @(posedge clk);
    #1;
    rx_vld  = 1'b0;
    rx_sof  = 1'b0;
    rx_eof  = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sends fb[0..n-1] as one frame; the first n_wr bytes are expected in the
  // buffer at addresses 0..n_wr-1.
  task automatic frame(input int n, input int n_wr);
    for (int i = 0; i < n; i++) begin
      if (i < n_wr) wq.push_back({i[5:0], fb[i]});
      send(fb[i], i == 0, i == n - 1);
    end
  endtask

  task automatic ack(input string name);
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    chk({name, "_rdy_after_ack"}, frame_rdy, 0);
    chk({name, "_busy_after_ack"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_wen", c_wen, 0);
    chk("rst_outputs", {c_addr, c_din, frame_rdy, frame_len, err_cksum, err_len, err_drop, busy}, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);

    // Good frame 01 02 03 FA
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'hFA;
    eq.push_back(1103);
    frame(4, 4);
    chk("good_rdy", frame_rdy, 1);
    chk("good_last_wen", {c_wen, c_addr}, {1'b1, 6'd3});
    tick(3);
    chk("good_len_hold", frame_len, 3);
    chk("good_busy_hold", busy, 1);
    ack("good");

    // Acknowledge outside HOLD is ignored
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    chk("stray_ack_busy", {busy, frame_rdy}, 0);
    tick(1);

    // Bad checksum 10 20 00
    fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h00;
    eq.push_back(2100);
    frame(3, 3);
    chk("cksum_pulse", err_cksum, 1);
    chk("cksum_idle", {busy, frame_rdy}, 0);
    tick(1);
    chk("cksum_one_cycle", err_cksum, 0);
    tick(2);

    // Overlong: 66 bytes, only 64 written, ERR_LEN after byte 65
    for (int i = 0; i < 66; i++) fb[i] = 8'(i + 8'h40);
    eq.push_back(3000);
    frame(66, 64);
    chk("long_idle", busy, 0);
    tick(3);

    // Exactly 64 bytes: maximum payload of 63
    for (int i = 0; i < 63; i++) fb[i] = 8'h01;
    fb[63] = 8'hC1;
    eq.push_back(1163);
    frame(64, 64);
    chk("max_len", frame_len, 63);
    tick(2);
    ack("max");
    tick(1);

    // Single byte with SOF and EOF together (sum would otherwise be OK)
    fb[0] = 8'h00;
    eq.push_back(3100);
    frame(1, 1);
    chk("short_idle", {busy, frame_rdy, err_cksum}, 0);
    tick(2);

    // Mid-frame restart
    wq.push_back({6'd0, 8'h01});
    send(8'h01, 1'b1, 1'b0);
    wq.push_back({6'd1, 8'h02});
    send(8'h02, 1'b0, 1'b0);
    fb[0] = 8'h03; fb[1] = 8'hFD;
    eq.push_back(1101);
    frame(2, 2);
    chk("restart_len", frame_len, 1);
    tick(2);
    ack("restart");
    tick(1);

    // Collision handling
    fb[0] = 8'h05; fb[1] = 8'hFB;
    eq.push_back(1101);
    frame(2, 2);
    tick(2);
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
    eq.push_back(4000);
    frame(3, 0);
    tick(2);
    chk("drop_hold_persists", {busy, frame_rdy, frame_len}, {1'b1, 1'b1, 6'd1});
    eq.push_back(4000);
    frame_ack = 1'b1;
    send(8'h11, 1'b1, 1'b0);
    frame_ack = 1'b0;
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b1);
    tick(2);
    chk("collide_idle", {busy, frame_rdy}, 0);
    fb[0] = 8'hAA; fb[1] = 8'h56;
    eq.push_back(1101);
    frame(2, 2);
    chk("after_collide_rdy", frame_rdy, 1);
    tick(1);
    ack("after_collide");
    tick(1);

    // Reset mid-frame after the 5th byte
    for (int i = 0; i < 5; i++) begin
      wq.push_back({i[5:0], 8'(i + 1)});
      send(8'(i + 1), i == 0, 1'b0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wen", c_wen, 0);
    chk("async_rst_outputs", {c_addr, c_din, busy, frame_rdy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    fb[0] = 8'h7F; fb[1] = 8'h81;
    eq.push_back(1101);
    frame(2, 2);
    chk("post_rst_rdy", frame_rdy, 1);
    tick(1);
    ack("post_rst");

    tick(3);
    chk("writes_drained", wq.size(), 0);
    chk("events_drained", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
